bit_serializer: RTL

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 12 +
 rtl/bit_serializer.sv | 57 +++++
 2 files changed

// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: state encodings shared by the serializer and its bench.
package bit_serializer_pkg;
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_SHIFT = 2'b01;
   localparam logic [1:0] ST_LAST  = 2'b10;
   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      LAST  = ST_LAST,
      BAD   = 2'b11
   } state_t;
endpackage

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial converter with valid/ready input handshake.
// Frames are WIDTH bits, emitted one per clock, back-to-back when input is ready.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             x,
   output logic             x_valid,
   output logic             frame_start,
   output logic             frame_done
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 2);
   state_t           state, nxt;
   logic [WIDTH-1:0] sreg, src;
   logic [CW-1:0]    cnt;
   logic             accept, advance;
   assign din_ready = rst && (state == IDLE || state == LAST);
   assign accept    = din_valid && din_ready;
   assign src       = accept ? din : sreg;
   assign advance   = nxt != IDLE;
   always_comb begin
      nxt = IDLE;
      case (state)
         IDLE, LAST: nxt = accept ? SHIFT : IDLE;
         SHIFT:      nxt = (cnt == CNT_LAST) ? LAST : SHIFT;
         default:    nxt = IDLE;
      endcase
   end
   // x is the bit leaving src this edge; sreg keeps the bits still to go
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         sreg        <= '0;
         cnt         <= '0;
         x           <= 1'b0;
         x_valid     <= 1'b0;
         frame_start <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         state       <= nxt;
         x_valid     <= advance;
         frame_start <= accept;
         frame_done  <= nxt == LAST;
         x           <= advance && (MSB_FIRST ? src[WIDTH-1] : src[0]);
         sreg        <= advance ? (MSB_FIRST ? src << 1 : src >> 1) : '0;
         cnt         <= (accept || !advance) ? '0 : cnt + 1'b1;
      end
   end
endmodule
